instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Writer side of the instruction-memory read port used by the single-cycle CPU fetch path.
//  - Receives a program image as a byte stream.
//  - Assembles the bytes into 32-bit words.
//  - Writes the words sequentially into instruction memory.
//  - Holds the CPU in reset until the image is loaded and its checksum has verified.
//  Sits between the board/testbench byte source and the instruction-memory write port.
// PARAMETERS
//  IMEM_WORDS  256  instruction-memory depth in words; also the upper bound on the image word count
//  BASE_ADDR   0    byte address of the first written word (word-aligned)
// PORTS
//  clk_i          in   1   system clock
//  rst_i          in   1   asynchronous, active-low reset
//  load_start_i   in   1   one-cycle pulse: begin a new load
//  byte_valid_i   in   1   byte_data_i holds a valid byte
//  byte_data_i    in   8   stream byte
//  byte_ready_o   out  1   loader accepts a byte this cycle
//  imem_we_o      out  1   instruction-memory write strobe (one cycle per word)
//  imem_addr_o    out  32  byte address of the write
//  imem_data_o    out  32  write data
//  cpu_rst_n_o    out  1   active-low reset to the CPU; 1 only in DONE
//  busy_o         out  1   load in progress (HDR0..CHK)
//  done_o         out  1   image loaded and checksum matched
//  err_o          out  1   load failed
//  err_code_o     out  2   0 none, 1 bad count, 2 checksum mismatch
//  words_o        out  16  number of words written in the current load
// BEHAVIOUR
//  Reset (rst_i=0): state IDLE and all outputs 0, including cpu_rst_n_o (CPU held).
//  Byte transfer occurs iff byte_valid_i && byte_ready_o at a rising clk_i edge.
//  byte_ready_o = 1 in HDR0, HDR1, DATA, CHK; 0 otherwise. There is no backpressure inside a load.
//  Stream format:
//   - COUNT_LO, COUNT_HI: 16-bit word count N.
//   - N x 4 data bytes, each word little-endian.
//   - 1 checksum byte = XOR of all 4N data bytes.
//  FSM:
//   - IDLE -start-> HDR0.
//   - HDR0 -byte-> HDR1 (latch count[7:0]).
//   - HDR1 -byte-> DATA if 1 <= N <= IMEM_WORDS; otherwise ERR with code 1.
//   - DATA: 4th byte of the final word -> CHK.
//   - CHK -byte-> DONE if the byte equals the running XOR; otherwise ERR with code 2.
//   - DONE and ERR -start-> HDR0: clears words_o, XOR and err state, and drives cpu_rst_n_o=0 the next cycle.
//   - load_start_i in HDR0..CHK is ignored.
//  Word write:
//   - The 4th byte of a word is accepted in cycle t.
//   - In cycle t+1: imem_we_o=1 for exactly one cycle, imem_addr_o = BASE_ADDR + 4*k (k = word index from 0), imem_data_o = {b3,b2,b1,b0}.
//   - words_o increments in the same cycle as the write.
//   - imem_addr_o/imem_data_o hold their last values when imem_we_o=0.
//  Back-to-back bytes every cycle are supported. The last word's write occurs in the cycle the checksum byte may arrive.
//  Output timing: cpu_rst_n_o, done_o, err_o and busy_o are registered. cpu_rst_n_o rises in the cycle after the checksum byte is accepted and the checksum matched.
//  Address: computed in 32 bits; N <= IMEM_WORDS guarantees no wrap past the end of memory.
//  Asynchronous reset during a load:
//   - Returns to IDLE immediately; any partial word is discarded.
//   - Memory contents already written are not reverted.
//   - CPU stays in reset.
// STRUCTURE
//  Package instr_loader_pkg:
//   - state enum {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR}
//   - ERR_NONE / ERR_COUNT / ERR_CSUM constants
//  Sub-module loader_word_asm:
//   - 2-bit byte-lane counter, 32-bit shift register and word_valid pulse.
//   - Cleared on rst_i and on load start.
//  Top level holds the FSM, word/address counter, XOR accumulator and status registers.
// TESTING
//  1. N=2, words 0x20080005 and 0x00000000, correct checksum, byte_valid_i held high:
//     two writes to addresses 0x0 and 0x4 with data 0x20080005 and 0x00000000; words_o=2; done_o=1; cpu_rst_n_o=1.
//  2. Header 0x0000, or header IMEM_WORDS+1:
//     ERR with err_code_o=1; no imem_we_o pulse; cpu_rst_n_o stays 0.
//  3. N=1, word 0x12345678, checksum 0x00 (correct value is 0x08):
//     one write at address 0x0 with data 0x12345678; then err_o=1, err_code_o=2, cpu_rst_n_o=0.
//  4. Random byte_valid_i gaps (about 50% duty), N=16:
//     data written matches the image; 16 write pulses; addresses 0x00..0x3C.
//  5. rst_i=0 after the 2nd byte of word 3, then a new start and a full N=4 load:
//     clean load, words_o=4, no stray write from the partial word.
//  6. load_start_i mid-load ignored; load_start_i in DONE:
//     cpu_rst_n_o goes to 0 the next cycle, busy_o=1, words_o=0.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// instr_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_e      : loader FSM states
//   ERR_*        : err_code_o encodings
//   is_busy()    : true for the states that consume stream bytes
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  // Byte-consuming states; the loader is always ready in these (no backpressure).
  function automatic logic is_busy(input state_e s);
    return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream input and instruction-memory write port.
//   byte_valid_i / byte_data_i / byte_ready_o : source -> loader byte handshake
//   imem_we_o / imem_addr_o / imem_data_o     : loader -> instruction memory write
//   slave  : loader side
//   master : byte source / memory side
interface instr_mem_loader_if;

  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_o;

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o
  );

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o
  );

endinterface

// File: rtl/instr_mem_loader_word_asm.sv
// loader_word_asm: packs four little-endian stream bytes into a 32-bit word.
//   clk_i, rst_i   : clock, async active-low reset
//   clr_i          : load start; drops any partial word
//   byte_en_i      : a data byte is transferred this cycle
//   byte_i         : the data byte
//   last_byte_o    : combinational, this byte completes a word
//   word_valid_o   : registered one-cycle pulse the cycle after completion
//   word_o         : last completed word; holds between completions
module loader_word_asm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q;
  logic [31:0] sh_q;
  logic [31:0] word_q;
  logic        vld_q;

  assign last_byte_o  = byte_en_i && (lane_q == 2'd3);
  assign word_valid_o = vld_q;
  assign word_o       = word_q;

  // Bytes enter at the top and shift down, so after b0..b2 the low 24 bits of
  // the completed word are {b2,b1,b0} = sh_q[31:8].
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lane_q <= '0;
      sh_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      // word_q is left alone: it backs imem_data_o, which must hold.
      lane_q <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= last_byte_o;
      if (byte_en_i) begin
        lane_q <= lane_q + 2'd1;
        sh_q   <= {byte_i, sh_q[31:8]};
        if (lane_q == 2'd3)
          word_q <= {byte_i, sh_q[31:8]};
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a program image from a byte stream into instruction
// memory and holds the CPU in reset until the image checksum verifies.
//   clk_i, rst_i   : clock, async active-low reset
//   load_start_i   : one-cycle pulse, begin a load (from IDLE/DONE/ERR)
//   bus            : byte stream in, imem write port out
//   cpu_rst_n_o    : CPU reset, released only in DONE
//   busy_o         : load in progress
//   done_o, err_o  : load outcome
//   err_code_o     : ERR_NONE / ERR_COUNT / ERR_CSUM
//   words_o        : words written in the current load
// Stream: COUNT_LO, COUNT_HI, N*4 data bytes (LE words), XOR checksum byte.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  instr_mem_loader_if.slave     bus,
  output logic                  cpu_rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [15:0]           words_o
);

  state_e      state_q, state_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        start_go;
  logic        xfer, data_xfer;
  logic [7:0]  count_lo_q;
  logic [15:0] count_q;
  logic [15:0] count_n;
  logic        count_ok;
  logic [15:0] words_q;
  logic [7:0]  xor_q;
  logic [31:0] addr_q;
  logic        final_word;
  logic        last_byte;
  logic        word_valid;
  logic [31:0] word;
  logic        busy_q, done_q, err_q, cpu_rst_n_q;

  assign bus.byte_ready_o = is_busy(state_q);
  assign xfer       = bus.byte_valid_i && bus.byte_ready_o;
  assign data_xfer  = xfer && (state_q == DATA);

  // Full count as seen while the high header byte is on the bus.
  assign count_n    = {bus.byte_data_i, count_lo_q};
  assign count_ok   = (count_n != 16'd0) && ({16'd0, count_n} <= IMEM_WORDS);
  assign final_word = (words_q + 16'd1) == count_q;

  loader_word_asm u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (start_go),
    .byte_en_i    (data_xfer),
    .byte_i       (bus.byte_data_i),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  assign bus.imem_we_o   = word_valid;
  assign bus.imem_addr_o = addr_q;
  assign bus.imem_data_o = word;

  assign cpu_rst_n_o = cpu_rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign words_o     = words_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and error code
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    start_go   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start_i) begin
          state_d    = HDR0;
          err_code_d = ERR_NONE;
          start_go   = 1'b1;
        end
      end
      HDR0: if (xfer) state_d = HDR1;
      HDR1: begin
        if (xfer) begin
          if (count_ok) begin
            state_d = DATA;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_COUNT;
          end
        end
      end
      DATA: if (last_byte && final_word) state_d = CHK;
      CHK: begin
        if (xfer) begin
          if (bus.byte_data_i == xor_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Header, word/address counter, checksum accumulator
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_lo_q <= '0;
      count_q    <= '0;
      words_q    <= '0;
      xor_q      <= '0;
      addr_q     <= '0;
    end else if (start_go) begin
      words_q <= '0;
      xor_q   <= '0;
    end else begin
      if (xfer && state_q == HDR0) count_lo_q <= bus.byte_data_i;
      if (xfer && state_q == HDR1) count_q    <= count_n;
      if (data_xfer)               xor_q      <= xor_q ^ bus.byte_data_i;
      // Counter and address move at the completing byte so they line up with
      // the registered write strobe one cycle later.
      if (last_byte) begin
        words_q <= words_q + 16'd1;
        addr_q  <= BASE_ADDR + (32'(words_q) << 2);
      end
    end
  end

  // Registered status, decoded from the next state so it tracks state_q exactly
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      busy_q      <= is_busy(state_d);
      done_q      <= (state_d == DONE);
      err_q       <= (state_d == ERR);
      cpu_rst_n_q <= (state_d == DONE);
      err_code_q  <= err_code_d;
    end
  end

endmodule
